// File: rtl/pulse_gen_mc_pkg.sv
// Shared types for the multi-channel pulse generator.
// The raw 2-bit mode code maps onto mode_t here; code 3 behaves as ONESHOT.
package pulse_gen_mc_pkg;

  typedef enum logic [1:0] {
    ONESHOT    = 2'd0,
    BURST      = 2'd1,
    CONTINUOUS = 2'd2
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic mode_t decode_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd1:    m = BURST;
      2'd2:    m = CONTINUOUS;
      default: m = ONESHOT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pulse_gen_ch.sv
// One pulse-generator channel: IDLE/RUN FSM, period and burst counters, shadowed settings.
// Outputs are registered from the next-state values, so they describe the cycle after each edge.
module pulse_gen_ch
  import pulse_gen_mc_pkg::*;
#(
  parameter int CNTR_WIDTH  = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [1:0]             mode_i,
  input  logic [CNTR_WIDTH-1:0]  cntr_max_i,
  input  logic [CNTR_WIDTH-1:0]  cntr_low_i,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  output logic                   pulse_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  state_t                 state_q, state_d;
  mode_t                  mode_q, mode_d;
  logic [CNTR_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNTR_WIDTH-1:0]  max_q, max_d;
  logic [CNTR_WIDTH-1:0]  low_q, low_d;
  logic [BURST_WIDTH-1:0] blen_q, blen_d;
  logic [BURST_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                   stop_flag_q, stop_flag_d;
  logic                   pulse_q, pulse_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   launch;
  logic                   run_end;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    max_d       = max_q;
    low_d       = low_q;
    blen_d      = blen_q;
    bcnt_d      = bcnt_q;
    stop_flag_d = stop_flag_q;
    launch      = 1'b0;

    case (state_q)
      IDLE: launch = start_i && !stop_i;
      RUN: begin
        stop_flag_d = stop_flag_q | stop_i;
        if (cnt_q != max_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (done_q) begin
          // Last cycle of the run: either restart seamlessly or fall back to IDLE.
          state_d     = IDLE;
          cnt_d       = '0;
          stop_flag_d = 1'b0;
          launch      = start_i && !stop_i;
        end else begin
          cnt_d = '0;
          max_d = cntr_max_i;
          low_d = cntr_low_i;
          if (mode_q == BURST) bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d     = RUN;
      mode_d      = decode_mode(mode_i);
      cnt_d       = '0;
      max_d       = cntr_max_i;
      low_d       = cntr_low_i;
      blen_d      = (burst_len_i == '0) ? BURST_ONE : burst_len_i;
      bcnt_d      = '0;
      stop_flag_d = 1'b0;
    end

    case (mode_d)
      BURST:      run_end = (bcnt_d == blen_d - 1'b1) || stop_flag_d;
      CONTINUOUS: run_end = stop_flag_d;
      default:    run_end = 1'b1;
    endcase

    busy_d  = (state_d == RUN);
    pulse_d = busy_d && (cnt_d >= low_d);
    done_d  = busy_d && (cnt_d == max_d) && run_end;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      mode_q      <= ONESHOT;
      cnt_q       <= '0;
      max_q       <= '0;
      low_q       <= '0;
      blen_q      <= '0;
      bcnt_q      <= '0;
      stop_flag_q <= 1'b0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      low_q       <= low_d;
      blen_q      <= blen_d;
      bcnt_q      <= bcnt_d;
      stop_flag_q <= stop_flag_d;
      pulse_q     <= pulse_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: rtl/pulse_gen_mc.sv
// Multi-channel pulse generator: CHANNELS fully independent pulse_gen_ch instances.
module pulse_gen_mc
  import pulse_gen_mc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int CNTR_WIDTH  = 8,
  parameter int BURST_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [CHANNELS-1:0]                   start,
  input  logic [CHANNELS-1:0]                   stop,
  input  logic [CHANNELS-1:0][1:0]              mode,
  input  logic [CHANNELS-1:0][CNTR_WIDTH-1:0]   cntr_max,
  input  logic [CHANNELS-1:0][CNTR_WIDTH-1:0]   cntr_low,
  input  logic [CHANNELS-1:0][BURST_WIDTH-1:0]  burst_len,
  output logic [CHANNELS-1:0]                   pulse_out,
  output logic [CHANNELS-1:0]                   busy,
  output logic [CHANNELS-1:0]                   done
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_gen_ch #(
      .CNTR_WIDTH  (CNTR_WIDTH),
      .BURST_WIDTH (BURST_WIDTH)
    ) u_ch (
      .clk         (clk),
      .nrst        (nrst),
      .start_i     (start[g]),
      .stop_i      (stop[g]),
      .mode_i      (mode[g]),
      .cntr_max_i  (cntr_max[g]),
      .cntr_low_i  (cntr_low[g]),
      .burst_len_i (burst_len[g]),
      .pulse_o     (pulse_out[g]),
      .busy_o      (busy[g]),
      .done_o      (done[g])
    );
  end

endmodule

// File: doc/pulse_gen_mc.md
# pulse_gen_mc

Multi-channel, parametrised successor to the single-channel pulse generator. Each of `CHANNELS` independent channels produces PWM-style periods of programmable length and duty in one of three run modes: one-shot, counted burst, or continuous until stopped. Period settings are shadow-latched, so duty and period can be changed on the fly without glitching a period already in progress. The block sits in the same clock domain as its control logic and drives timing strobes, LED/PWM outputs and test stimulus.

## Interface
- `CHANNELS`, 4, number of independent channels (≥1)
- `CNTR_WIDTH`, 8, width of period/duty counters
- `BURST_WIDTH`, 8, width of burst period count
- `clk`  in  1  single clock; all logic on rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `start`  in  [CHANNELS]  per-channel run request, level-sampled
- `stop`  in  [CHANNELS]  per-channel graceful stop request, level-sampled
- `mode`  in  [CHANNELS][2]  0 ONESHOT, 1 BURST, 2 CONTINUOUS, 3 treated as ONESHOT
- `cntr_max`  in  [CHANNELS][CNTR_WIDTH]  period length minus one
- `cntr_low`  in  [CHANNELS][CNTR_WIDTH]  low cycles at start of each period
- `burst_len`  in  [CHANNELS][BURST_WIDTH]  periods per BURST run; 0 treated as 1
- `pulse_out`  out  [CHANNELS]  registered pulse output
- `busy`  out  [CHANNELS]  high while the channel is in RUN
- `done`  out  [CHANNELS]  one-cycle strobe on the final cycle of a run

## Operation
- Per-channel FSM: IDLE, RUN. Channels never interact.
- IDLE → RUN when `start`=1 and `stop`=0. On that transition, latch `mode`, `cntr_max`, `cntr_low` and `burst_len` into shadow registers. Clear the period counter `cnt` and the burst counter.
- In RUN, `cnt` counts 0..shadow `cntr_max`, then wraps to 0. `pulse_out` = (`cnt` ≥ shadow `cntr_low`).
  - `cntr_low`=0 → high for the whole period.
  - `cntr_low` > `cntr_max` → low for the whole period.
- Period boundary = the cycle with `cnt`==shadow `cntr_max`. At each boundary, re-latch `cntr_max` and `cntr_low` only; `mode` and `burst_len` stay fixed for the run.
- Run end, evaluated at each boundary:
  - ONESHOT: first boundary.
  - BURST: boundary of period number `burst_len`.
  - CONTINUOUS: first boundary at or after `stop` was sampled high. `stop` is held in a sticky flag until then.
  - `stop` in ONESHOT/BURST also ends the run at the next boundary.
- At run end, assert `done`. If `start`=1 and `stop`=0 on that same cycle, restart immediately: re-latch all settings, keep `busy` high, no gap cycle. Otherwise go to IDLE.
- `start` while in RUN is ignored, except at the run-end cycle as described above. `start`=`stop`=1 in IDLE: stop wins, and the channel stays IDLE.
- Counter arithmetic is unsigned and modulo 2^`CNTR_WIDTH`. `cntr_max`=2^`CNTR_WIDTH`−1 gives the maximal period with no overflow hazard.

## Timing
- All outputs are registered. Reset values while `nrst`=0: `pulse_out`=0, `busy`=0, `done`=0, FSM IDLE, all counters, shadows and the stop flag at 0.
- `nrst` asserted mid-run clears everything asynchronously. After release, the first action is on the first rising edge with `start` sampled.
- `start` sampled high at edge N → `busy`=1 and `cnt`=0 from cycle N+1. `pulse_out` reflects `cnt`=0 in cycle N+1 (one-cycle latency).
- Run length: (`cntr_max`+1) × periods cycles of `busy`. `done` coincides with the last of those cycles. `busy` falls the next cycle unless the run restarts.
- `cntr_max`=0: 1-cycle periods. `pulse_out` = (`cntr_low`==0).
- Stop latency: at most `cntr_max`+1 cycles. The current period always completes, so there is no truncated pulse.

## Structure
- Package `pulse_gen_mc_pkg`: `mode_t` enum (ONESHOT, BURST, CONTINUOUS), `state_t` enum (IDLE, RUN).
- Sub-module `pulse_gen_ch`: one channel holding the FSM, counters and shadows. The top level is a generate loop over `CHANNELS` instances plus port slicing.

## Test plan
- Reset: hold `nrst`=0 with `start`=all ones → all outputs 0. Release → `busy` rises 1 cycle after the first sampled edge.
- ONESHOT, `cntr_max`=15, `cntr_low`=4, `start` pulse at edge 10 → `busy` on cycles 11–26, `pulse_out` low 11–14 and high 15–26, `done` on 26 only.
- BURST, `cntr_max`=3, `cntr_low`=1, `burst_len`=3 → `pulse_out` 0111 0111 0111, `busy` for 12 cycles, a single `done`. `burst_len`=0 → one period.
- CONTINUOUS, `cntr_max`=7, `cntr_low`=2; change `cntr_low` to 6 mid-period → change appears only from the next period. `stop` pulse mid-period → that period completes, then `done` and `busy` fall.
- ONESHOT with `start` held high, `cntr_max`=15, `cntr_low` random per period → back-to-back periods with `busy` constantly 1, `done` every 16 cycles, each period's duty matching the value latched at its start.
- Channel independence and async reset: run 4 channels with distinct settings and check cycle-exact per-channel outputs. Assert `nrst` mid-period → all outputs 0 immediately, without waiting for a clock edge.
